// File: rtl/inst_issue_queue_if.sv
// rtl/inst_issue_queue_if.sv - fetch/decode side signal bundle for the instruction issue queue
interface inst_issue_queue_if;
    logic        flush_i;
    logic        stall_i;
    logic        fetch_valid1_i;
    logic        fetch_valid2_i;
    logic [31:0] fetch_inst1_i;
    logic [31:0] fetch_inst2_i;
    logic [31:0] fetch_addr1_i;
    logic [31:0] fetch_addr2_i;
    logic        full_o;
    logic [31:0] inst1_o;
    logic [31:0] inst2_o;
    logic [31:0] inst1_addr_o;
    logic [31:0] inst2_addr_o;
    logic        is_in_delayslot_o;
    logic        issue_en_o;
    logic        issue_i;
    logic        issued_i;
    logic        ninst_in_delayslot_i;

    modport master (
        output flush_i, stall_i, fetch_valid1_i, fetch_valid2_i,
               fetch_inst1_i, fetch_inst2_i, fetch_addr1_i, fetch_addr2_i,
               issue_i, issued_i, ninst_in_delayslot_i,
        input  full_o, inst1_o, inst2_o, inst1_addr_o, inst2_addr_o,
               is_in_delayslot_o, issue_en_o
    );

    modport slave (
        input  flush_i, stall_i, fetch_valid1_i, fetch_valid2_i,
               fetch_inst1_i, fetch_inst2_i, fetch_addr1_i, fetch_addr2_i,
               issue_i, issued_i, ninst_in_delayslot_i,
        output full_o, inst1_o, inst2_o, inst1_addr_o, inst2_addr_o,
               is_in_delayslot_o, issue_en_o
    );
endinterface

// File: rtl/inst_issue_queue.sv
// rtl/inst_issue_queue.sv - dual-write dual-read instruction buffer between fetch and dual-issue decode
module inst_issue_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    inst_issue_queue_if.slave bus
);
    localparam logic              DUAL_ISSUE  = 1'b1;
    localparam logic [PTR_W:0]    FULL_THRESH = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0]    PAIR        = (PTR_W+1)'(2);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic             r_flag;
    logic [31:0]      r_inst_mem [DEPTH];
    logic [31:0]      r_addr_mem [DEPTH];

    logic             w_full;
    logic             w_issue_en;
    logic             w_push1;
    logic             w_push2;
    logic             w_pop;
    logic             w_pop2;
    logic [PTR_W:0]   w_npush;
    logic [PTR_W:0]   w_npop;
    logic [PTR_W-1:0] w_head1;
    logic [PTR_W-1:0] w_tail1;

    // full is taken from the registered count, so a same-cycle pop never frees room early
    assign w_full     = (r_count > FULL_THRESH);
    assign w_issue_en = (r_count >= PAIR);
    assign w_push1    = !bus.flush_i && !w_full && bus.fetch_valid1_i;
    assign w_push2    = w_push1 && bus.fetch_valid2_i;
    assign w_pop      = !bus.flush_i && w_issue_en && bus.issued_i && !bus.stall_i;
    assign w_pop2     = w_pop && (bus.issue_i == DUAL_ISSUE);
    assign w_head1    = r_head + 1'b1;
    assign w_tail1    = r_tail + 1'b1;

    always_comb begin
        w_npush = '0;
        w_npop  = '0;
        if (w_push2)
            w_npush = (PTR_W+1)'(2);
        else if (w_push1)
            w_npush = (PTR_W+1)'(1);
        if (w_pop2)
            w_npop = (PTR_W+1)'(2);
        else if (w_pop)
            w_npop = (PTR_W+1)'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_flag  <= 1'b0;
        end else if (bus.flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_head  <= r_head + w_npop[PTR_W-1:0];
            r_tail  <= r_tail + w_npush[PTR_W-1:0];
            r_count <= r_count + w_npush - w_npop;
            if (w_pop)
                r_flag <= bus.ninst_in_delayslot_i;
        end
    end

    // Storage needs no reset: outputs are masked by count until an entry is written
    always_ff @(posedge clk) begin
        if (w_push1) begin
            r_inst_mem[r_tail] <= bus.fetch_inst1_i;
            r_addr_mem[r_tail] <= bus.fetch_addr1_i;
        end
        if (w_push2) begin
            r_inst_mem[w_tail1] <= bus.fetch_inst2_i;
            r_addr_mem[w_tail1] <= bus.fetch_addr2_i;
        end
    end

    assign bus.full_o            = w_full;
    assign bus.issue_en_o        = w_issue_en;
    assign bus.is_in_delayslot_o = r_flag;
    assign bus.inst1_o           = (r_count != '0) ? r_inst_mem[r_head]  : 32'h0;
    assign bus.inst1_addr_o      = (r_count != '0) ? r_addr_mem[r_head]  : 32'h0;
    assign bus.inst2_o           = w_issue_en      ? r_inst_mem[w_head1] : 32'h0;
    assign bus.inst2_addr_o      = w_issue_en      ? r_addr_mem[w_head1] : 32'h0;
endmodule

// File: tb/tb_inst_issue_queue.sv
// tb/tb_inst_issue_queue.sv - scoreboard bench for inst_issue_queue
module tb_inst_issue_queue;
    logic clk;
    logic rst;
    inst_issue_queue_if bus();

    inst_issue_queue #(.DEPTH(16), .PTR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          m_count = 0;
    bit          m_flag = 1'b0;
    bit          mon_en = 1'b0;
    logic [63:0] sb[$];

    function automatic logic [31:0] f_inst(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; the model effect is committed at the clock edge
    task automatic cyc(input bit v1, input bit v2, input logic [31:0] a1, input logic [31:0] a2,
                       input bit iss, input bit dual, input bit ninst, input bit stall, input bit flush);
        int np;
        int npop;
        bus.fetch_valid1_i       = v1;
        bus.fetch_valid2_i       = v2;
        bus.fetch_addr1_i        = a1;
        bus.fetch_addr2_i        = a2;
        bus.fetch_inst1_i        = f_inst(a1);
        bus.fetch_inst2_i        = f_inst(a2);
        bus.issued_i             = iss;
        bus.issue_i              = dual;
        bus.ninst_in_delayslot_i = ninst;
        bus.stall_i              = stall;
        bus.flush_i              = flush;
        np   = (!flush && m_count < 15 && v1) ? (v2 ? 2 : 1) : 0;
        npop = (!flush && m_count >= 2 && iss && !stall) ? (dual ? 2 : 1) : 0;
        if (np >= 1) sb.push_back({a1, f_inst(a1)});
        if (np == 2) sb.push_back({a2, f_inst(a2)});
        @(posedge clk);
        if (flush) begin
            m_count = 0;
            m_flag  = 1'b0;
            sb.delete();
        end else begin
            m_count = m_count + np - npop;
            if (npop != 0) m_flag = ninst;
        end
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push2(input logic [31:0] a1, input logic [31:0] a2);
        cyc(1, 1, a1, a2, 0, 0, 0, 0, 0);
    endtask

    task automatic pop(input bit dual, input bit ninst);
        cyc(0, 0, 0, 0, 1, dual, ninst, 0, 0);
    endtask

    // Monitor: checks presented state every cycle and retires scoreboard entries on each pop
    always @(negedge clk) begin
        logic [63:0] e1;
        logic [63:0] e2;
        logic [63:0] got;
        if (rst && mon_en) begin
            e1 = (m_count >= 1 && sb.size() >= 1) ? sb[0] : 64'h0;
            e2 = (m_count >= 2 && sb.size() >= 2) ? sb[1] : 64'h0;
            chk("issue_en", {63'h0, bus.issue_en_o}, {63'h0, m_count >= 2});
            chk("full", {63'h0, bus.full_o}, {63'h0, m_count >= 15});
            chk("delayslot", {63'h0, bus.is_in_delayslot_o}, {63'h0, m_flag});
            chk("head", {bus.inst1_addr_o, bus.inst1_o}, e1);
            chk("head1", {bus.inst2_addr_o, bus.inst2_o}, e2);
            if (bus.issue_en_o && bus.issued_i && !bus.stall_i && !bus.flush_i) begin
                for (int i = 0; i < (bus.issue_i ? 2 : 1); i++) begin
                    got = (i == 0) ? {bus.inst1_addr_o, bus.inst1_o} : {bus.inst2_addr_o, bus.inst2_o};
                    if (sb.size() == 0) begin
                        chk("sb_empty", got, 64'hDEAD_DEAD_DEAD_DEAD);
                    end else begin
                        chk("sb_pop", got, sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int pushed;
        int k;
        rst = 1'b0;
        bus.flush_i = 0; bus.stall_i = 0; bus.fetch_valid1_i = 0; bus.fetch_valid2_i = 0;
        bus.fetch_inst1_i = 0; bus.fetch_inst2_i = 0; bus.fetch_addr1_i = 0; bus.fetch_addr2_i = 0;
        bus.issue_i = 0; bus.issued_i = 0; bus.ninst_in_delayslot_i = 0;
        #12;
        chk("rst_full", {63'h0, bus.full_o}, 64'h0);
        chk("rst_issue_en", {63'h0, bus.issue_en_o}, 64'h0);
        chk("rst_dslot", {63'h0, bus.is_in_delayslot_o}, 64'h0);
        chk("rst_inst", {bus.inst1_o, bus.inst2_o}, 64'h0);
        chk("rst_addr", {bus.inst1_addr_o, bus.inst2_addr_o}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b1;
        idle(); idle();

        // Two pairs, two dual pops
        push2(32'hA0, 32'hA4);
        push2(32'hA8, 32'hAC);
        chk("pair_a0", {bus.inst1_addr_o, bus.inst2_addr_o}, {32'hA0, 32'hA4});
        pop(1, 0);
        chk("pair_a8", {bus.inst1_addr_o, bus.inst2_addr_o}, {32'hA8, 32'hAC});
        pop(1, 0);
        chk("drained", {63'h0, bus.issue_en_o}, 64'h0);
        idle();

        // Three entries, single pop into delay slot, then dual pop clears it
        push2(32'hB0, 32'hB4);
        cyc(1, 0, 32'hB8, 0, 0, 0, 0, 0, 0);
        pop(0, 1);
        chk("ds_head", {32'h0, bus.inst1_addr_o}, 64'hB4);
        chk("ds_flag", {63'h0, bus.is_in_delayslot_o}, 64'h1);
        pop(1, 0);
        chk("ds_clear", {63'h0, bus.is_in_delayslot_o}, 64'h0);
        idle();

        // Fill to 16; a further push is ignored; one dual pop frees room
        for (int i = 0; i < 8; i++) begin
            chk("not_full_yet", {63'h0, bus.full_o}, 64'h0);
            push2(32'h1000 + 8 * i, 32'h1004 + 8 * i);
        end
        chk("full_at_16", {63'h0, bus.full_o}, 64'h1);
        push2(32'h9990, 32'h9994);
        pop(1, 0);
        chk("full_released", {63'h0, bus.full_o}, 64'h0);
        for (int i = 0; i < 7; i++) pop(1, 0);
        idle();

        // Wrap-around with concurrent pushes and mixed pops
        pushed = 0;
        k = 0;
        while ((pushed < 40 || m_count >= 2) && k < 300) begin
            bit do_push;
            bit two;
            do_push = (pushed < 40) && (k % 5 != 4);
            two = (pushed <= 38);
            if (do_push && m_count < 15) pushed += two ? 2 : 1;
            cyc(do_push, two, 32'h2000 + 4 * pushed, 32'h2004 + 4 * pushed,
                (k % 3) != 2, (k % 3) == 1, 0, 0, 0);
            k++;
        end
        chk("wrap_bound", k < 300, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Flush with count 5, flag set and a concurrent push
        push2(32'h3000, 32'h3004);
        push2(32'h3008, 32'h300C);
        push2(32'h3010, 32'h3014);
        pop(0, 1);
        chk("pre_flush_flag", {63'h0, bus.is_in_delayslot_o}, 64'h1);
        cyc(1, 1, 32'hC0, 32'hC4, 0, 0, 0, 0, 1);
        chk("flush_issue_en", {63'h0, bus.issue_en_o}, 64'h0);
        chk("flush_flag", {63'h0, bus.is_in_delayslot_o}, 64'h0);
        chk("flush_inst", {bus.inst1_addr_o, bus.inst1_o}, 64'h0);
        push2(32'hD0, 32'hD4);
        chk("post_flush_head", {32'h0, bus.inst1_addr_o}, 64'hD0);

        // Stall blocks retirement
        cyc(0, 0, 0, 0, 1, 1, 1, 1, 0);
        chk("stall_hold", {bus.inst1_addr_o, bus.inst2_addr_o}, {32'hD0, 32'hD4});
        chk("stall_flag", {63'h0, bus.is_in_delayslot_o}, 64'h0);
        pop(1, 0);

        // Asynchronous reset mid-operation
        push2(32'hE0, 32'hE4);
        push2(32'hE8, 32'hEC);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_issue_en", {63'h0, bus.issue_en_o}, 64'h0);
        chk("async_rst_inst", {bus.inst1_addr_o, bus.inst1_o}, 64'h0);
        m_count = 0;
        m_flag = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        push2(32'hF0, 32'hF4);
        pop(1, 0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
